// File: rtl/io_input_pkg.sv
// rtl/io_input_pkg.sv - shared constants for the input-port bank
//   IO_WORD_W        : CPU I/O bus word width
//   DEFAULT_BASE_SEL : word index (addr[7:2]) of port 0
//   status_ofs/mask_ofs : register offsets from BASE_SEL, as functions of NPORTS
package io_input_pkg;

  localparam int IO_WORD_W = 32;
  localparam logic [5:0] DEFAULT_BASE_SEL = 6'h30;

  // STATUS sits directly after the last port, MASK right after STATUS.
  function automatic int status_ofs(input int nports);
    return nports;
  endfunction

  function automatic int mask_ofs(input int nports);
    return nports + 1;
  endfunction

endpackage

// File: rtl/io_input_sync.sv
// rtl/io_input_sync.sv - one port's multi-stage synchroniser with change detect
//   clk   in  : sampling clock
//   reset in  : synchronous active-high, flushes every stage to 0
//   d_in  in  : asynchronous input bus
//   q_out out : synchronised value (last stage)
//   chg   out : last two stages differ, i.e. q_out changes on the next edge
module io_input_sync #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out,
  output logic             chg
);

  logic [WIDTH-1:0] s_q [SYNC_STAGES];
  logic [WIDTH-1:0] s_d [SYNC_STAGES];

  always_comb begin
    s_d[0] = d_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      s_d[i] = s_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < SYNC_STAGES; i++) begin
      if (reset) begin
        s_q[i] <= '0;
      end else begin
        s_q[i] <= s_d[i];
      end
    end
  end

  assign q_out = s_q[SYNC_STAGES-1];
  // Sampled by the flag register on the same edge the new value lands in
  // the last stage, so the flag and the visible value move together.
  assign chg   = (s_q[SYNC_STAGES-2] != s_q[SYNC_STAGES-1]);

endmodule

// File: rtl/io_input_bank.sv
// rtl/io_input_bank.sv - memory-mapped input-port bank with sticky change flags and irq
//   io_clk       in  : I/O clock
//   reset        in  : synchronous active-high
//   addr         in  : bus address, only addr[7:2] decoded
//   io_wr        in  : write strobe
//   io_wdata     in  : write data
//   in_port      in  : NPORTS buses of WIDTH bits, asynchronous
//   io_read_data out : combinational read mux
//   irq          out : |(chg_flag & irq_mask)
module io_input_bank
  import io_input_pkg::*;
#(
  parameter int         NPORTS      = 2,
  parameter int         WIDTH       = 32,
  parameter logic [5:0] BASE_SEL    = DEFAULT_BASE_SEL,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                    io_clk,
  input  logic                    reset,
  input  logic [31:0]             addr,
  input  logic                    io_wr,
  input  logic [31:0]             io_wdata,
  input  logic [NPORTS*WIDTH-1:0] in_port,
  output logic [31:0]             io_read_data,
  output logic                    irq
);

  localparam int         STATUS_OFS = status_ofs(NPORTS);
  localparam int         MASK_OFS   = mask_ofs(NPORTS);
  localparam logic [5:0] STATUS_SEL = 6'(int'(BASE_SEL) + STATUS_OFS);
  localparam logic [5:0] MASK_SEL   = 6'(int'(BASE_SEL) + MASK_OFS);

  if ((int'(BASE_SEL) + MASK_OFS > 63) || (WIDTH < 1) || (WIDTH > IO_WORD_W) ||
      (SYNC_STAGES < 2) || (NPORTS < 1) || (NPORTS > 16)) begin : g_bad_params
    $error("io_input_bank: illegal parameter combination");
  end

  logic [5:0] idx;
  logic       is_status;
  logic       is_mask;
  logic       addr_unused;
  logic       wdata_unused;

  assign idx          = addr[7:2];
  assign is_status    = (idx == STATUS_SEL);
  assign is_mask      = (idx == MASK_SEL);
  assign addr_unused  = ^{addr[31:8], addr[1:0]};
  assign wdata_unused = ^io_wdata[IO_WORD_W-1:NPORTS];

  logic [NPORTS-1:0][WIDTH-1:0] port_val;
  logic [NPORTS-1:0]            chg_pulse;

  for (genvar k = 0; k < NPORTS; k++) begin : g_sync
    io_input_sync #(
      .WIDTH      (WIDTH),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk  (io_clk),
      .reset(reset),
      .d_in (in_port[k*WIDTH +: WIDTH]),
      .q_out(port_val[k]),
      .chg  (chg_pulse[k])
    );
  end

  logic [NPORTS-1:0] chg_flag_q, chg_flag_d;
  logic [NPORTS-1:0] irq_mask_q, irq_mask_d;
  logic [NPORTS-1:0] clr_bits;

  always_comb begin
    clr_bits   = '0;
    irq_mask_d = irq_mask_q;
    if (io_wr && is_status) begin
      clr_bits = io_wdata[NPORTS-1:0];
    end
    if (io_wr && is_mask) begin
      irq_mask_d = io_wdata[NPORTS-1:0];
    end
    // Set after clear: a change landing on a W1C edge is not lost.
    chg_flag_d = (chg_flag_q & ~clr_bits) | chg_pulse;
  end

  always_ff @(posedge io_clk) begin
    if (reset) begin
      chg_flag_q <= '0;
      irq_mask_q <= '0;
    end else begin
      chg_flag_q <= chg_flag_d;
      irq_mask_q <= irq_mask_d;
    end
  end

  always_comb begin
    io_read_data = '0;
    for (int k = 0; k < NPORTS; k++) begin
      if (idx == 6'(int'(BASE_SEL) + k)) begin
        io_read_data[WIDTH-1:0] = port_val[k];
      end
    end
    if (is_status) begin
      io_read_data[NPORTS-1:0] = chg_flag_q;
    end
    if (is_mask) begin
      io_read_data[NPORTS-1:0] = irq_mask_q;
    end
  end

  assign irq = |(chg_flag_q & irq_mask_q);

endmodule

// File: doc/io_input_bank.md
Name: io_input_bank

Overview:
Parametrised memory-mapped input-port bank. It samples NPORTS external input buses through a multi-stage synchroniser and latches a sticky per-port change flag. It provides a maskable interrupt and a combinational read mux decoded on addr[7:2]. It sits on the CPU I/O bus beside the output-port bank, and the CPU reads it through the io_read_data path.

Parameters:
NPORTS, 2, number of input ports (1..16)
WIDTH, 32, bits per input port (1..32); zero-extended to 32 on read
BASE_SEL, 6'h30, word index (addr[7:2]) of port 0 (byte address 192)
SYNC_STAGES, 2, synchroniser depth (2..4)

Ports:
io_clk  in  1  I/O clock; all state updates on its rising edge
reset  in  1  synchronous, active-high reset
addr  in  32  bus address; only addr[7:2] decoded, addr[1:0] and addr[31:8] ignored
io_wr  in  1  write strobe, sampled at rising io_clk
io_wdata  in  32  write data
in_port  in  NPORTS*WIDTH  port k occupies bits [k*WIDTH +: WIDTH]; asynchronous to io_clk
io_read_data  out  32  combinational read data selected by addr[7:2]
irq  out  1  OR of (chg_flag & irq_mask); combinational from registers

Behaviour:
- One clock (io_clk). Reset is synchronous and active-high: when reset=1 at a rising edge, all synchroniser stages, chg_flag[NPORTS-1:0] and irq_mask[NPORTS-1:0] clear to 0. io_wr is ignored in that cycle.
- Reset values after that edge:
  - io_read_data = 0 for any index.
  - irq = 0.
- Register map by idx = addr[7:2]:
  - BASE_SEL+k (k<NPORTS): read sync value of port k, zero-extended; writes ignored.
  - BASE_SEL+NPORTS (STATUS): read {zeros, chg_flag}; write = write-1-to-clear of chg_flag using io_wdata[NPORTS-1:0].
  - BASE_SEL+NPORTS+1 (MASK): read/write irq_mask from io_wdata[NPORTS-1:0]; upper bits read 0.
  - Any other idx reads 32'h0; writes have no effect.
- Synchroniser per port: stages s[0..SYNC_STAGES-1]; s[0] <= in_port slice; s[i] <= s[i-1]. Visible value = s[SYNC_STAGES-1].
- Latency: a change on in_port before edge t is readable after edge t+SYNC_STAGES-1. That is 2 edges for SYNC_STAGES=2.
- Change flag: at each edge, if s[SYNC_STAGES-2] != s[SYNC_STAGES-1], set chg_flag[k]. The flag rises on the same edge the new value becomes visible.
- Simultaneous set and W1C clear on the same port in the same cycle: set wins and the flag stays 1.
- MASK write and STATUS clear are independent. irq updates combinationally with either of them.
- A change that reverts before it is read still sets the flag, which stays sticky. Only the final synchronised value is readable.
- Pulses narrower than one io_clk period may be missed. This is accepted; no glitch capture.
- Reset mid-operation flushes the synchroniser. After release the first sampled value is compared against 0, so a nonzero input sets chg_flag SYNC_STAGES-1 edges after reset falls.
- Elaboration check: BASE_SEL+NPORTS+1 <= 63; WIDTH <= 32; SYNC_STAGES >= 2. Violation = $error.

Decomposition:
- Shared package io_input_pkg:
  - IO_WORD_W = 32.
  - Default BASE_SEL.
  - Localparam offsets STATUS_OFS = NPORTS and MASK_OFS = NPORTS+1, expressed as functions of NPORTS.
- Sub-module io_input_sync: one port's WIDTH x SYNC_STAGES synchroniser plus change-detect pulse output. Instantiated NPORTS times in a generate loop.
- Top-level: flag/mask registers, decode, read mux, irq.

Test Plan:
1. Reset and latency: assert reset 2 cycles with in_port[31:0]=32'hA5A5_0001, then release. STATUS reads 0 and port0 reads 0 during reset. Port0 reads 32'hA5A5_0001 and STATUS bit0=1 exactly SYNC_STAGES-1 edges after release.
2. Read map: NPORTS=2, addr=192 gives port0 and addr=196 gives port1. addr=193 aliases to 192. addr=208 (idx 52, unmapped) gives 32'h0.
3. Sticky flag and irq:
   - Write MASK (addr=204) with 32'h2, change port1 from 0 to 32'h7, wait 3 cycles. STATUS=32'h2 and irq=1.
   - Write STATUS with 32'h2. Next cycle STATUS=0 and irq=0.
4. Set/clear collision: time a W1C of bit0 on the same edge port0's new value becomes visible -> STATUS bit0 stays 1.
5. Mask gating: flag0=1 with MASK=0 -> irq=0. Write MASK=1 -> irq=1 the next cycle with no other change.
6. Glitch revert: port0 goes 0 -> 5 -> 0 across two cycles. Port0 ends reading 0 and STATUS bit0=1. Parameter sweep with WIDTH=8 confirms io_read_data[31:8]=0.
